// File: rtl/switch_button_in.sv
// ---------------------------------------------------------------------------
// switch_button_in
//
// Memory-mapped input peripheral sharing the data-memory bus with the LED
// output device. Synchronises and debounces 16 slide switches and NUM_BTN
// push buttons, latches button presses into sticky write-1-to-clear flags,
// keeps a saturating press counter and returns everything through a
// registered read port.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-low reset
//   writeData    bus write data
//   writeEnable  bus write strobe (one cycle per write)
//   readEnable   bus read strobe
//   memAddress   bus address, only [4:2] decoded
//   switches     raw asynchronous switch pins
//   buttons      raw asynchronous button pins, active-high
//   readData     registered read data, valid the cycle after readEnable
//   irq          press-event interrupt (0 unless SWITCH_BUTTON_IRQ_EN)
//
// Register map (word offset memAddress[4:2]):
//   0 SWITCH   RO   {16'b0, debounced switches}
//   1 BUTTON   RO   debounced buttons, zero-extended
//   2 EVENT    W1C  sticky press flags; a set on the same edge wins
//   3 COUNT    RWC  8-bit saturating press count; any write clears it
//   4 IRQ_MASK RW   only with SWITCH_BUTTON_IRQ_EN, otherwise reads 0
//   5..7            read 0, writes ignored
//
// Build option: define SWITCH_BUTTON_IRQ_EN to add IRQ_MASK and drive irq.
// ---------------------------------------------------------------------------
module switch_button_in #(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        writeData,
  input  logic               writeEnable,
  input  logic               readEnable,
  input  logic [31:0]        memAddress,
  input  logic [15:0]        switches,
  input  logic [NUM_BTN-1:0] buttons,
  output logic [31:0]        readData,
  output logic               irq
);

  localparam int NIN = 16 + NUM_BTN;
  localparam int CW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] OFF_SWITCH = 3'd0;
  localparam logic [2:0] OFF_BUTTON = 3'd1;
  localparam logic [2:0] OFF_EVENT  = 3'd2;
  localparam logic [2:0] OFF_COUNT  = 3'd3;
  localparam logic [2:0] OFF_MASK   = 3'd4;

  // -------------------------------------------------------------------------
  // Synchroniser: switches and buttons share one vector so a single
  // debounce loop covers every pin.
  // -------------------------------------------------------------------------
  logic [NIN-1:0] raw;
  logic [NIN-1:0] sync1;
  logic [NIN-1:0] sync2;
  logic [NIN-1:0] deb;
  logic [CW-1:0]  cnt [NIN];

  assign raw = {buttons, switches};

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // -------------------------------------------------------------------------
  // Debounce: each bit counts consecutive edges on which the synchronised
  // value disagrees with the debounced one; any agreeing edge restarts the
  // count. The DEBOUNCE_CYCLES-th disagreeing edge flips the output, so the
  // counter never needs to hold DEBOUNCE_CYCLES itself.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      deb <= '0;
      for (int unsigned i = 0; i < NIN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NIN; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  logic [15:0]        deb_sw;
  logic [NUM_BTN-1:0] deb_btn;

  assign deb_sw  = deb[15:0];
  assign deb_btn = deb[NIN-1:16];

  // -------------------------------------------------------------------------
  // Press detection: a rising debounced button is seen one edge after it
  // rises, which is when EVENT and COUNT pick it up.
  // -------------------------------------------------------------------------
  logic [NUM_BTN-1:0] deb_btn_d;
  logic [NUM_BTN-1:0] rise;
  logic [4:0]         rise_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      deb_btn_d <= '0;
    end else begin
      deb_btn_d <= deb_btn;
    end
  end

  assign rise = deb_btn & ~deb_btn_d;

  always_comb begin
    rise_cnt = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      rise_cnt = rise_cnt + 5'(rise[i]);
    end
  end

  // -------------------------------------------------------------------------
  // Bus write decode
  // -------------------------------------------------------------------------
  logic [2:0] offset;
  logic       wr_event;
  logic       wr_count;

  assign offset   = memAddress[4:2];
  assign wr_event = writeEnable && (offset == OFF_EVENT);
  assign wr_count = writeEnable && (offset == OFF_COUNT);

  // -------------------------------------------------------------------------
  // EVENT flags: clear first, then OR in new presses so a set on the same
  // edge as its clear survives.
  // -------------------------------------------------------------------------
  logic [NUM_BTN-1:0] evt_flags;
  logic [NUM_BTN-1:0] evt_clr;

  assign evt_clr = wr_event ? writeData[NUM_BTN-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      evt_flags <= '0;
    end else begin
      evt_flags <= (evt_flags & ~evt_clr) | rise;
    end
  end

  // -------------------------------------------------------------------------
  // COUNT: a write restarts from this edge's presses rather than from zero,
  // so presses coincident with the clear are not lost.
  // -------------------------------------------------------------------------
  logic [7:0] press_count;
  logic [8:0] count_sum;
  logic [7:0] count_next;

  assign count_sum = {1'b0, press_count} + 9'(rise_cnt);

  always_comb begin
    count_next = press_count;
    if (wr_count) begin
      count_next = 8'(rise_cnt);
    end else if (count_sum[8]) begin
      count_next = 8'hFF;
    end else begin
      count_next = count_sum[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      press_count <= '0;
    end else begin
      press_count <= count_next;
    end
  end

  // -------------------------------------------------------------------------
  // Optional interrupt
  // -------------------------------------------------------------------------
  logic [31:0] mask_word;

`ifdef SWITCH_BUTTON_IRQ_EN
  logic               wr_mask;
  logic [NUM_BTN-1:0] irq_mask;

  assign wr_mask = writeEnable && (offset == OFF_MASK);

  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_mask) begin
        irq_mask <= writeData[NUM_BTN-1:0];
      end
      irq <= |(evt_flags & irq_mask);
    end
  end

  assign mask_word = 32'(irq_mask);
`else
  assign irq       = 1'b0;
  assign mask_word = '0;
`endif

  // -------------------------------------------------------------------------
  // Read port: samples the pre-update register values of the read edge.
  // -------------------------------------------------------------------------
  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    case (offset)
      OFF_SWITCH: rd_word = {16'b0, deb_sw};
      OFF_BUTTON: rd_word = 32'(deb_btn);
      OFF_EVENT:  rd_word = 32'(evt_flags);
      OFF_COUNT:  rd_word = {24'b0, press_count};
      OFF_MASK:   rd_word = mask_word;
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      readData <= '0;
    end else if (readEnable) begin
      readData <= rd_word;
    end
  end

  // Address bits outside the word offset and data bits above the button
  // field carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{memAddress[31:5], memAddress[1:0], writeData[31:NUM_BTN]};

endmodule

// File: tb/tb_switch_button_in.sv
// ---------------------------------------------------------------------------
// tb_switch_button_in
//
// Directed bench for switch_button_in with DEBOUNCE_CYCLES=4, NUM_BTN=5.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_switch_button_in;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] writeData;
  logic        writeEnable;
  logic        readEnable;
  logic [31:0] memAddress;
  logic [15:0] switches;
  logic [4:0]  buttons;
  logic [31:0] readData;
  logic        irq;

  int vectors     = 0;
  int miscompares = 0;

  switch_button_in #(
    .NUM_BTN         (5),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .writeData   (writeData),
    .writeEnable (writeEnable),
    .readEnable  (readEnable),
    .memAddress  (memAddress),
    .switches    (switches),
    .buttons     (buttons),
    .readData    (readData),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Upper and lowest address bits carry noise to show they are ignored.
  function automatic logic [31:0] addr(input logic [2:0] off);
    return {27'h0ABCDEF, off, 2'b01};
  endfunction

  task automatic wr_reg(input logic [2:0] off, input logic [31:0] data);
    memAddress  = addr(off);
    writeData   = data;
    writeEnable = 1'b1;
    @(negedge clk);
    writeEnable = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] off, input logic [31:0] exp);
    memAddress = addr(off);
    readEnable = 1'b1;
    @(negedge clk);
    readEnable = 1'b0;
    check(tag, readData, exp);
  endtask

  task automatic press(input logic [4:0] mask);
    buttons = mask;
    cyc(8);
    buttons = '0;
    cyc(8);
  endtask

  initial begin
    rst         = 1'b0;
    writeData   = '0;
    writeEnable = 1'b0;
    readEnable  = 1'b0;
    memAddress  = '0;
    switches    = '0;
    buttons     = '0;
    cyc(2);
    rst = 1'b1;

    // Reset state
    check("rst_readData", readData, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    for (int i = 0; i < 5; i++) begin
      check_reg($sformatf("rst_off%0d", i), 3'(i), 32'h0);
    end

    // Switch debounce: read held on, sample k reflects deb before posedge k
    switches   = 16'hA5C3;
    memAddress = addr(3'd0);
    readEnable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("sw_lat_%0d", k), readData, (k <= 5) ? 32'h0 : 32'h0000A5C3);
    end
    readEnable = 1'b0;

    // 2-cycle glitch rejected
    switches = 16'hFFFF;
    cyc(2);
    switches = 16'hA5C3;
    cyc(10);
    check_reg("sw_glitch", 3'd0, 32'h0000A5C3);

    // Button 2 press / release
    buttons = 5'b00100;
    cyc(10);
    check_reg("btn_held", 3'd1, 32'h4);
    buttons = '0;
    cyc(10);
    check_reg("btn_released", 3'd1, 32'h0);
    check_reg("evt_btn2", 3'd2, 32'h4);
    check_reg("cnt_one", 3'd3, 32'h1);
    wr_reg(3'd2, 32'h4);
    check_reg("evt_w1c", 3'd2, 32'h0);

    // Saturation
    for (int n = 0; n < 300; n++) begin
      press(5'b00001);
    end
    check_reg("cnt_sat", 3'd3, 32'd255);
    check_reg("evt_btn0", 3'd2, 32'h1);
    wr_reg(3'd3, 32'hDEAD0000);
    check_reg("cnt_clear", 3'd3, 32'h0);
    press(5'b00001);
    check_reg("cnt_after_clear", 3'd3, 32'h1);

    // Write to COUNT on the edge where buttons 1 and 3 register
    buttons = 5'b01010;
    cyc(6);
    wr_reg(3'd3, 32'h0);
    check_reg("cnt_coincident", 3'd3, 32'h2);
    buttons = '0;
    cyc(8);
    check_reg("evt_multi", 3'd2, 32'hB);
    wr_reg(3'd2, 32'hFFFFFFFF);
    check_reg("evt_clr_all", 3'd2, 32'h0);

    // Set and W1C of bit 1 on the same edge: set wins
    buttons = 5'b00010;
    cyc(6);
    wr_reg(3'd2, 32'h2);
    check_reg("evt_set_wins", 3'd2, 32'h2);
    buttons = '0;
    cyc(8);

    // Read and write on the same edge: old value returned, write applied
    memAddress  = addr(3'd2);
    writeData   = 32'h2;
    readEnable  = 1'b1;
    writeEnable = 1'b1;
    @(negedge clk);
    readEnable  = 1'b0;
    writeEnable = 1'b0;
    check("rw_same_old", readData, 32'h2);
    check_reg("rw_same_new", 3'd2, 32'h0);

    // Read-only and unmapped offsets
    wr_reg(3'd0, 32'h0000FFFF);
    check_reg("sw_ro", 3'd0, 32'h0000A5C3);
    wr_reg(3'd1, 32'hFFFFFFFF);
    check_reg("btn_ro", 3'd1, 32'h0);
    wr_reg(3'd6, 32'hFFFFFFFF);
    check_reg("off6", 3'd6, 32'h0);
    check_reg("off5", 3'd5, 32'h0);
    check_reg("cnt_running", 3'd3, 32'h3);

`ifdef SWITCH_BUTTON_IRQ_EN
    wr_reg(3'd4, 32'hFFFFFFE2);
    check_reg("mask_rd", 3'd4, 32'h2);
    press(5'b00001);
    check("irq_masked", 32'(irq), 32'h0);
    check_reg("evt_masked", 3'd2, 32'h1);
    buttons = 5'b00010;
    cyc(6);
    @(negedge clk);
    check("irq_evt_edge", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_set", 32'(irq), 32'h1);
    buttons = '0;
    cyc(8);
    check("irq_hold", 32'(irq), 32'h1);
    wr_reg(3'd2, 32'h2);
    @(negedge clk);
    check("irq_w1c", 32'(irq), 32'h0);
    press(5'b00010);
    check("irq_again", 32'(irq), 32'h1);
    wr_reg(3'd4, 32'h0);
    @(negedge clk);
    check("irq_unmask", 32'(irq), 32'h0);
`else
    wr_reg(3'd4, 32'hFFFFFFFF);
    check_reg("mask_absent", 3'd4, 32'h0);
    press(5'b00010);
    check_reg("evt_noirq", 3'd2, 32'h2);
    check("irq_tied", 32'(irq), 32'h0);
`endif

    // Reset mid-debounce with a button held through it
    buttons = 5'b00001;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    check("rst2_readData", readData, 32'h0);
    check_reg("rst2_evt", 3'd2, 32'h0);
    cyc(10);
    check_reg("held_thru_rst_evt", 3'd2, 32'h1);
    check_reg("held_thru_rst_cnt", 3'd3, 32'h1);
    buttons = '0;
    cyc(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
